// File: rtl/housekeeping_spi_sync_if.sv
// SPI pins and register-file bus of the oversampled housekeeping SPI slave.
interface housekeeping_spi_sync_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              sck;
  logic              sdi;
  logic              csb;
  logic              sdo;
  logic              sdoenb;
  logic [DATA_W-1:0] idata;
  logic [DATA_W-1:0] odata;
  logic [ADDR_W-1:0] oaddr;
  logic              rdstb;
  logic              wrstb;
  logic              busy;

  // slave is the SPI block; master drives the pins and answers reads.
  modport slave (
    input  sck, sdi, csb, idata,
    output sdo, sdoenb, odata, oaddr, rdstb, wrstb, busy
  );

  modport master (
    output sck, sdi, csb, idata,
    input  sdo, sdoenb, odata, oaddr, rdstb, wrstb, busy
  );
endinterface

// File: rtl/housekeeping_spi_sync.sv
// Housekeeping SPI slave (mode 0, MSB first) oversampled on the system clock;
// decodes command/address/data frames into single-cycle rdstb/wrstb strobes.
module housekeeping_spi_sync #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  resetn,
  housekeeping_spi_sync_if.slave bus
);
  localparam int FIELD_MAX = (DATA_W > ADDR_W) ? ((DATA_W > 8) ? DATA_W : 8)
                                               : ((ADDR_W > 8) ? ADDR_W : 8);
  localparam int CNT_W     = $clog2(FIELD_MAX);

  typedef enum logic [1:0] {IDLE, COMMAND, ADDRESS, DATA} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, csb_sync;
  logic                   sck_prev;
  logic                   sck_s, sdi_s, csb_s, rise, fall;

  logic [CNT_W-1:0]       bit_cnt;
  logic [FIELD_MAX-2:0]   shift_in;
  logic [FIELD_MAX-1:0]   shift_next;
  logic [DATA_W-1:0]      out_shift;
  logic                   wr_mode, rd_mode;
  logic [2:0]             nnn, words_left;
  logic                   first_fall;
  logic                   rd_req, inc_req, rd_next;
  logic [ADDR_W-1:0]      oaddr;
  logic [DATA_W-1:0]      odata;
  logic                   rdstb, wrstb;
  logic                   cmd_done, addr_done, word_done, last_word;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would chain the synchroniser stages.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sck_sync <= '0;
      sdi_sync <= '0;
      csb_sync <= '1;
      sck_prev <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], bus.sdi};
      csb_sync <= {csb_sync[SYNC_STAGES-2:0], bus.csb};
      sck_prev <= sck_s;
    end
  end

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign sdi_s = sdi_sync[SYNC_STAGES-1];
  assign csb_s = csb_sync[SYNC_STAGES-1];
  assign rise  = sck_s & ~sck_prev;
  assign fall  = ~sck_s & sck_prev;

  assign shift_next = {shift_in, sdi_s};
  assign cmd_done   = (state == COMMAND) && rise && (bit_cnt == CNT_W'(7));
  assign addr_done  = (state == ADDRESS) && rise && (bit_cnt == CNT_W'(ADDR_W - 1));
  assign word_done  = (state == DATA) && rise && (bit_cnt == CNT_W'(DATA_W - 1));
  assign last_word  = (nnn != 3'd0) && (words_left == 3'd1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: next state is defaulted to the current state before the case so
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!csb_s)                 state_next = COMMAND;
      COMMAND: if (cmd_done)               state_next = ADDRESS;
      ADDRESS: if (addr_done)              state_next = DATA;
      DATA:    if (word_done && last_word) state_next = COMMAND;
      default:                             state_next = IDLE;
    endcase
    if (csb_s) state_next = IDLE;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bit_cnt    <= '0;
      shift_in   <= '0;
      out_shift  <= '0;
      wr_mode    <= 1'b0;
      rd_mode    <= 1'b0;
      nnn        <= 3'd0;
      words_left <= 3'd0;
      first_fall <= 1'b0;
      rd_req     <= 1'b0;
      inc_req    <= 1'b0;
      rd_next    <= 1'b0;
      oaddr      <= '0;
      odata      <= '0;
      rdstb      <= 1'b0;
      wrstb      <= 1'b0;
    end else begin
      rdstb <= 1'b0;
      wrstb <= 1'b0;
      if (csb_s) begin
        // Frame abort: drop everything in flight, keep oaddr/odata.
        bit_cnt    <= '0;
        shift_in   <= '0;
        out_shift  <= '0;
        wr_mode    <= 1'b0;
        rd_mode    <= 1'b0;
        nnn        <= 3'd0;
        words_left <= 3'd0;
        first_fall <= 1'b0;
        rd_req     <= 1'b0;
        inc_req    <= 1'b0;
        rd_next    <= 1'b0;
      end else begin
        rdstb   <= rd_req;
        rd_req  <= 1'b0;
        inc_req <= 1'b0;
        if (inc_req) begin
          oaddr  <= oaddr + ADDR_W'(1);
          rd_req <= rd_next;
        end

        if (rise && state != IDLE) begin
          shift_in <= shift_next[FIELD_MAX-2:0];
          bit_cnt  <= bit_cnt + CNT_W'(1);
          if (cmd_done) begin
            wr_mode    <= shift_in[6];
            rd_mode    <= shift_in[5];
            nnn        <= shift_in[4:2];
            words_left <= shift_in[4:2];
            bit_cnt    <= '0;
            shift_in   <= '0;
          end
          if (addr_done) begin
            oaddr      <= shift_next[ADDR_W-1:0];
            rd_req     <= rd_mode;
            first_fall <= 1'b1;
            bit_cnt    <= '0;
            shift_in   <= '0;
          end
          if (word_done) begin
            odata      <= shift_next[DATA_W-1:0];
            wrstb      <= wr_mode;
            inc_req    <= 1'b1;
            rd_next    <= rd_mode && !last_word;
            first_fall <= 1'b1;
            bit_cnt    <= '0;
            shift_in   <= '0;
            if (nnn != 3'd0) words_left <= words_left - 3'd1;
          end
        end

        // First fall of a word loads the read data; later falls shift it out.
        if (fall && state == DATA) begin
          first_fall <= 1'b0;
          if (first_fall) out_shift <= bus.idata;
          else            out_shift <= {out_shift[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  assign bus.sdo    = out_shift[DATA_W-1];
  assign bus.sdoenb = !((state == DATA) && rd_mode);
  assign bus.odata  = odata;
  assign bus.oaddr  = oaddr;
  assign bus.rdstb  = rdstb;
  assign bus.wrstb  = wrstb;
  assign bus.busy   = ~csb_s;
endmodule

// File: tb/tb_housekeeping_spi_sync.sv
// Directed bench for housekeeping_spi_sync: an 8/8 instance and a 16/32
// instance share sck/sdi; each has its own csb and read data.
module tb_housekeeping_spi_sync;
  localparam int HALF = 8;

  logic        clock = 1'b0;
  logic        resetn;
  logic        sck, sdi, csb_n, csb_w;
  logic [7:0]  idata_n;
  logic [31:0] idata_w;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          use_wide = 1'b0;
  bit          in_data  = 1'b0;
  int          en_low_cnt, en_out_cnt, both_cnt;
  logic [31:0] sdo_cap;

  logic [31:0] ev_n[$], dat_n[$], ev_w[$], dat_w[$];
  logic [31:0] exp_ev[$], exp_dat[$];

  housekeeping_spi_sync_if #(.ADDR_W(8),  .DATA_W(8))  hk ();
  housekeeping_spi_sync_if #(.ADDR_W(16), .DATA_W(32)) hw ();

  assign hk.sck = sck;  assign hk.sdi = sdi;  assign hk.csb = csb_n;  assign hk.idata = idata_n;
  assign hw.sck = sck;  assign hw.sdi = sdi;  assign hw.csb = csb_w;  assign hw.idata = idata_w;

  housekeeping_spi_sync #(.ADDR_W(8), .DATA_W(8), .SYNC_STAGES(2)) dut_n (
    .clock(clock), .resetn(resetn), .bus(hk.slave)
  );
  housekeeping_spi_sync #(.ADDR_W(16), .DATA_W(32), .SYNC_STAGES(3)) dut_w (
    .clock(clock), .resetn(resetn), .bus(hw.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] wr_ev(input logic [15:0] a);
    return {8'h57, 8'h00, a};
  endfunction
  function automatic logic [31:0] rd_ev(input logic [15:0] a);
    return {8'h52, 8'h00, a};
  endfunction

  always @(negedge clock) begin
    if (hk.wrstb) begin ev_n.push_back(wr_ev({8'h00, hk.oaddr})); dat_n.push_back({24'h0, hk.odata}); end
    if (hk.rdstb) ev_n.push_back(rd_ev({8'h00, hk.oaddr}));
    if (hw.wrstb) begin ev_w.push_back(wr_ev(hw.oaddr)); dat_w.push_back(hw.odata); end
    if (hw.rdstb) ev_w.push_back(rd_ev(hw.oaddr));
    if ((hk.rdstb && hk.wrstb) || (hw.rdstb && hw.wrstb)) both_cnt++;
    if (!hk.sdoenb) begin
      en_low_cnt++;
      if (!in_data) en_out_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compares the strobe log of one instance against exp_ev/exp_dat, then clears.
  task automatic check_log(input string tag, input bit wide);
    logic [31:0] ev[$], dat[$];
    ev  = wide ? ev_w  : ev_n;
    dat = wide ? dat_w : dat_n;
    check({tag, " events"}, ev.size(), exp_ev.size());
    for (int i = 0; i < exp_ev.size() && i < ev.size(); i++)
      check($sformatf("%s ev%0d", tag, i), ev[i], exp_ev[i]);
    check({tag, " words"}, dat.size(), exp_dat.size());
    for (int i = 0; i < exp_dat.size() && i < dat.size(); i++)
      check($sformatf("%s data%0d", tag, i), dat[i], exp_dat[i]);
    ev_n.delete(); dat_n.delete(); ev_w.delete(); dat_w.delete();
    exp_ev.delete(); exp_dat.delete();
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic xfer(input int nbits, input logic [31:0] val);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = val[i];
      wait_clk(HALF);
      sdo_cap = {sdo_cap[30:0], (use_wide ? hw.sdo : hk.sdo)};
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic frame_begin();
    if (use_wide) csb_w = 1'b0;
    else          csb_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic frame_end();
    wait_clk(HALF);
    csb_n = 1'b1;
    csb_w = 1'b1;
    wait_clk(10);
  endtask

  task automatic clear_counts();
    en_low_cnt = 0;
    en_out_cnt = 0;
  endtask

  initial begin
    resetn = 1'b0; sck = 1'b0; sdi = 1'b0; csb_n = 1'b1; csb_w = 1'b1;
    idata_n = 8'h00; idata_w = 32'h0; sdo_cap = '0; both_cnt = 0;
    clear_counts();
    wait_clk(3);
    check("rst sdo",    hk.sdo,    1'b0);
    check("rst sdoenb", hk.sdoenb, 1'b1);
    check("rst odata",  hk.odata,  8'h00);
    check("rst oaddr",  hk.oaddr,  8'h00);
    check("rst rdstb",  hk.rdstb,  1'b0);
    check("rst wrstb",  hk.wrstb,  1'b0);
    check("rst busy",   hk.busy,   1'b0);
    check("rst w odata", hw.odata, 32'h0);
    resetn = 1'b1;
    wait_clk(3);

    // Single write
    clear_counts();
    frame_begin();
    wait_clk(1);
    check("t1 busy", hk.busy, 1'b1);
    xfer(8, 32'h88); xfer(8, 32'h10); xfer(8, 32'hA5);
    frame_end();
    exp_ev.push_back(wr_ev(16'h10)); exp_dat.push_back(32'hA5);
    check_log("t1", 1'b0);
    check("t1 sdoenb low", en_low_cnt, 0);
    check("t1 odata", hk.odata, 8'hA5);
    check("t1 oaddr inc", hk.oaddr, 8'h11);

    // Single read returning 0x3C
    clear_counts();
    idata_n = 8'h3C;
    frame_begin();
    xfer(8, 32'h48); xfer(7, 32'h10);
    in_data = 1'b1;
    xfer(1, 32'h0);
    sdo_cap = '0;
    xfer(8, 32'h00);
    in_data = 1'b0;
    frame_end();
    exp_ev.push_back(rd_ev(16'h20));
    check_log("t2", 1'b0);
    check("t2 sdo bits", sdo_cap[7:0], 8'h3C);
    check("t2 sdoenb low in data", en_low_cnt > 0, 1'b1);
    check("t2 sdoenb low outside", en_out_cnt, 0);

    // Streaming write across the address wrap
    frame_begin();
    xfer(8, 32'h80); xfer(8, 32'hFE);
    xfer(8, 32'h11); xfer(8, 32'h22); xfer(8, 32'h33);
    frame_end();
    exp_ev.push_back(wr_ev(16'hFE)); exp_ev.push_back(wr_ev(16'hFF)); exp_ev.push_back(wr_ev(16'h00));
    exp_dat.push_back(32'h11); exp_dat.push_back(32'h22); exp_dat.push_back(32'h33);
    check_log("t3", 1'b0);
    check("t3 oaddr", hk.oaddr, 8'h01);

    // Fixed count r/w (nnn=2), then a second command in the same frame
    idata_n = 8'h00;
    frame_begin();
    xfer(8, 32'hD0); xfer(8, 32'h05); xfer(8, 32'h5A); xfer(8, 32'hC3);
    xfer(8, 32'h88); xfer(8, 32'h40); xfer(8, 32'h77);
    frame_end();
    exp_ev.push_back(rd_ev(16'h05)); exp_ev.push_back(wr_ev(16'h05));
    exp_ev.push_back(rd_ev(16'h06)); exp_ev.push_back(wr_ev(16'h06));
    exp_ev.push_back(wr_ev(16'h40));
    exp_dat.push_back(32'h5A); exp_dat.push_back(32'hC3); exp_dat.push_back(32'h77);
    check_log("t4", 1'b0);

    // csb abort after 5 data bits, then a normal frame
    frame_begin();
    xfer(8, 32'h88); xfer(8, 32'h30); xfer(5, 32'h15);
    csb_n = 1'b1;
    wait_clk(10);
    check_log("t5 abort", 1'b0);
    check("t5 sdoenb", hk.sdoenb, 1'b1);
    check("t5 busy",   hk.busy,   1'b0);
    check("t5 oaddr hold", hk.oaddr, 8'h30);
    check("t5 odata hold", hk.odata, 8'h77);
    frame_begin();
    xfer(8, 32'h88); xfer(8, 32'h31); xfer(8, 32'h99);
    frame_end();
    exp_ev.push_back(wr_ev(16'h31)); exp_dat.push_back(32'h99);
    check_log("t5 next", 1'b0);

    // Reset in the middle of a read data word
    idata_n = 8'hFF;
    clear_counts();
    frame_begin();
    xfer(8, 32'h48); xfer(7, 32'h28);
    in_data = 1'b1;
    xfer(1, 32'h0); xfer(3, 32'h0);
    wait_clk(2);
    check("t6 pre sdoenb", hk.sdoenb, 1'b0);
    check("t6 pre sdo",    hk.sdo,    1'b1);
    check("t6 pre oaddr",  hk.oaddr,  8'h50);
    resetn = 1'b0;
    #1;
    check("t6 rst sdo",    hk.sdo,    1'b0);
    check("t6 rst sdoenb", hk.sdoenb, 1'b1);
    check("t6 rst odata",  hk.odata,  8'h00);
    check("t6 rst oaddr",  hk.oaddr,  8'h00);
    check("t6 rst rdstb",  hk.rdstb,  1'b0);
    check("t6 rst wrstb",  hk.wrstb,  1'b0);
    check("t6 rst busy",   hk.busy,   1'b0);
    in_data = 1'b0;
    csb_n = 1'b1;
    wait_clk(4);
    resetn = 1'b1;
    wait_clk(4);
    exp_ev.push_back(rd_ev(16'h50));
    check_log("t6", 1'b0);

    // Wide configuration, simultaneous read/write of one word
    use_wide = 1'b1;
    idata_w  = 32'hCAFEF00D;
    frame_begin();
    xfer(8, 32'hC8); xfer(16, 32'h1234);
    sdo_cap = '0;
    xfer(32, 32'hDEADBEEF);
    frame_end();
    exp_ev.push_back(rd_ev(16'h1234)); exp_ev.push_back(wr_ev(16'h1234));
    exp_dat.push_back(32'hDEADBEEF);
    check_log("t7", 1'b1);
    check("t7 sdo word", sdo_cap, 32'hCAFEF00D);
    check("t7 odata", hw.odata, 32'hDEADBEEF);
    check("t7 oaddr inc", hw.oaddr, 16'h1235);
    check("t7 sdoenb", hw.sdoenb, 1'b1);

    check("rd_wr_exclusive", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
